// File: rtl/palindrome_job_sequencer_pkg.sv
// Shared definitions for the palindrome job sequencer: index width, FSM
// encoding and the bit positions of the response flag vector.
package palindrome_job_sequencer_pkg;

    localparam int SEQ_AW = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_REPORT  = 2'd3
    } seq_state_t;

    localparam int FLAG_PAL = 0;
    localparam int FLAG_ERR = 1;
    localparam int FLAG_TMO = 2;
    localparam int NFLAGS   = 3;

endpackage

// File: rtl/palindrome_req_fifo.sv
// Small request FIFO holding {base, ending} pairs; DEPTH must be a power of 2
// so the pointers wrap naturally.
module palindrome_req_fifo
    import palindrome_job_sequencer_pkg::*;
#(
    parameter int W     = 2 * SEQ_AW,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/palindrome_job_sequencer.sv
// Queues (base, ending) requests and runs them one at a time through the
// palindrome checker's go/done handshake, returning one response per request.
module palindrome_job_sequencer
    import palindrome_job_sequencer_pkg::*;
#(
    parameter int AW      = SEQ_AW,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_base,
    input  logic [AW-1:0] req_ending,
    output logic          chk_go,
    output logic [AW-1:0] chk_base,
    output logic [AW-1:0] chk_ending,
    input  logic          chk_done,
    input  logic          chk_palindrome,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_palindrome,
    output logic          rsp_error,
    output logic          rsp_timeout,
    output logic [AW-1:0] rsp_base,
    output logic [AW-1:0] rsp_ending,
    output logic          busy
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    seq_state_t        r_state, w_state_nxt;
    logic              r_chk_go, w_chk_go_nxt;
    logic [AW-1:0]     r_chk_base, w_chk_base_nxt;
    logic [AW-1:0]     r_chk_ending, w_chk_ending_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [AW-1:0]     r_rsp_base, w_rsp_base_nxt;
    logic [AW-1:0]     r_rsp_ending, w_rsp_ending_nxt;
    logic [NFLAGS-1:0] r_flags, w_flags_nxt;
    logic [WDW-1:0]    r_wd, w_wd_nxt;

    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic [2*AW-1:0]       w_head;
    logic [AW-1:0]         w_head_base;
    logic [AW-1:0]         w_head_ending;
    logic                  w_wd_limit;

    palindrome_req_fifo #(
        .W     (2 * AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (req_valid),
        .i_data  ({req_base, req_ending}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_base   = w_head[2*AW-1:AW];
    assign w_head_ending = w_head[AW-1:0];
    assign w_wd_limit    = (r_wd == WDW'(TIMEOUT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_chk_go     <= 1'b0;
            r_chk_base   <= '0;
            r_chk_ending <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_base   <= '0;
            r_rsp_ending <= '0;
            r_flags      <= '0;
            r_wd         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_chk_go     <= w_chk_go_nxt;
            r_chk_base   <= w_chk_base_nxt;
            r_chk_ending <= w_chk_ending_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_base   <= w_rsp_base_nxt;
            r_rsp_ending <= w_rsp_ending_nxt;
            r_flags      <= w_flags_nxt;
            r_wd         <= w_wd_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_chk_go_nxt     = r_chk_go;
        w_chk_base_nxt   = r_chk_base;
        w_chk_ending_nxt = r_chk_ending;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_base_nxt   = r_rsp_base;
        w_rsp_ending_nxt = r_rsp_ending;
        w_flags_nxt      = r_flags;
        w_pop            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop            = 1'b1;
                    w_rsp_base_nxt   = w_head_base;
                    w_rsp_ending_nxt = w_head_ending;
                    w_flags_nxt      = '0;
                    if (w_head_base > w_head_ending) begin
                        w_flags_nxt[FLAG_ERR] = 1'b1;
                        w_rsp_valid_nxt       = 1'b1;
                        w_state_nxt           = S_REPORT;
                    end else begin
                        w_chk_base_nxt   = w_head_base;
                        w_chk_ending_nxt = w_head_ending;
                        w_chk_go_nxt     = 1'b1;
                        w_state_nxt      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (chk_done) begin
                    w_flags_nxt[FLAG_PAL] = chk_palindrome;
                    w_chk_go_nxt          = 1'b0;
                    w_state_nxt           = S_RELEASE;
                end else if (w_wd_limit) begin
                    w_flags_nxt[FLAG_TMO] = 1'b1;
                    w_chk_go_nxt          = 1'b0;
                    w_state_nxt           = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!chk_done) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_REPORT;
                end else if (w_wd_limit) begin
                    // A verdict latched before a stuck done is not trusted.
                    w_flags_nxt[FLAG_TMO] = 1'b1;
                    w_flags_nxt[FLAG_PAL] = 1'b0;
                    w_rsp_valid_nxt       = 1'b1;
                    w_state_nxt           = S_REPORT;
                end
            end
            S_REPORT: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Watchdog restarts on every state change and saturates at TIMEOUT.
        if (w_state_nxt != r_state) begin
            w_wd_nxt = '0;
        end else if (w_wd_limit) begin
            w_wd_nxt = r_wd;
        end else begin
            w_wd_nxt = r_wd + WDW'(1);
        end
    end

    assign req_ready      = ~w_full;
    assign chk_go         = r_chk_go;
    assign chk_base       = r_chk_base;
    assign chk_ending     = r_chk_ending;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_palindrome = r_flags[FLAG_PAL] & ~r_flags[FLAG_ERR] & ~r_flags[FLAG_TMO];
    assign rsp_error      = r_flags[FLAG_ERR];
    assign rsp_timeout    = r_flags[FLAG_TMO];
    assign rsp_base       = r_rsp_base;
    assign rsp_ending     = r_rsp_ending;
    assign busy           = (r_state != S_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_palindrome_job_sequencer.sv
// Directed bench for palindrome_job_sequencer with a behavioural word-level
// palindrome checker responding on the go/done handshake.
module tb_palindrome_job_sequencer;

    localparam int AW      = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_base;
    logic [AW-1:0] req_ending;
    logic          chk_go;
    logic [AW-1:0] chk_base;
    logic [AW-1:0] chk_ending;
    logic          chk_done;
    logic          chk_palindrome;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_palindrome;
    logic          rsp_error;
    logic          rsp_timeout;
    logic [AW-1:0] rsp_base;
    logic [AW-1:0] rsp_ending;
    logic          busy;

    always #5 clock = ~clock;

    palindrome_job_sequencer #(
        .AW      (AW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_base       (req_base),
        .req_ending     (req_ending),
        .chk_go         (chk_go),
        .chk_base       (chk_base),
        .chk_ending     (chk_ending),
        .chk_done       (chk_done),
        .chk_palindrome (chk_palindrome),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_palindrome (rsp_palindrome),
        .rsp_error      (rsp_error),
        .rsp_timeout    (rsp_timeout),
        .rsp_base       (rsp_base),
        .rsp_ending     (rsp_ending),
        .busy           (busy)
    );

    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q [$];

    logic m_hang  = 1'b0;
    logic m_spur  = 1'b0;
    int   m_cnt   = 0;
    int   go_rises = 0;
    logic go_prev = 1'b0;

    function automatic logic pal_fn(input logic [AW-1:0] b, input logic [AW-1:0] e);
        int i;
        int j;
        i = int'(b);
        j = int'(e);
        while (i < j) begin
            if (regs[i] != regs[j]) return 1'b0;
            i++;
            j--;
        end
        return 1'b1;
    endfunction

    function automatic logic [12:0] pack(input logic pal, input logic err, input logic tmo,
                                         input logic [AW-1:0] b, input logic [AW-1:0] e);
        return {pal, err, tmo, b, e};
    endfunction

    // Checker model: answers a few cycles after go, holds done until go drops.
    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            chk_done       = 1'b0;
            chk_palindrome = 1'b0;
            m_cnt          = 0;
            go_prev        = 1'b0;
        end else begin
            if (chk_go && !go_prev) go_rises++;
            go_prev = chk_go;
            if (m_spur) begin
                chk_done = 1'b1;
            end else if (m_hang) begin
                chk_done       = 1'b0;
                chk_palindrome = 1'b0;
            end else if (chk_go && !chk_done) begin
                m_cnt++;
                if (m_cnt >= 3) begin
                    chk_done       = 1'b1;
                    chk_palindrome = pal_fn(chk_base, chk_ending);
                    m_cnt          = 0;
                end
            end else if (!chk_go && chk_done) begin
                chk_done       = 1'b0;
                chk_palindrome = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [AW-1:0] b, input logic [AW-1:0] e);
        int n;
        n = 0;
        req_valid  = 1'b1;
        req_base   = b;
        req_ending = e;
        while (!req_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) check("push_timeout", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int          n;
        logic [12:0] exp;
        logic [12:0] obs;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_seen"}, 32'(rsp_valid), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1fff;
        obs = {rsp_palindrome, rsp_error, rsp_timeout, rsp_base, rsp_ending};
        check(tag, 32'(obs), 32'(exp));
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [AW-1:0] t3b [6];
        logic [AW-1:0] t3e [6];
        logic [12:0]   t3x [6];
        int            acc;
        int            g0;
        int            n;
        logic          seen_valid;
        logic          seen_go;

        req_valid  = 1'b0;
        req_base   = '0;
        req_ending = '0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[2]  = 32'hCAFEBABE; regs[3]  = 32'd1; regs[4] = 32'd5;
        regs[5]  = 32'd1;        regs[6]  = 32'hCAFEBABE;
        regs[7]  = 32'd1;        regs[8]  = 32'd2; regs[9] = 32'd3; regs[10] = 32'd4;
        regs[11] = 32'd12344321; regs[12] = 32'd0; regs[13] = 32'd0;
        regs[14] = 32'd12344321;

        // Reset values
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_chk_go", 32'(chk_go), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chk_base", 32'(chk_base), 32'd0);
        check("rst_rsp_flags", 32'({rsp_palindrome, rsp_error, rsp_timeout}), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // 1: even-length palindrome, pop-to-go latency of one cycle
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 5'd11, 5'd14));
        push_req(5'd11, 5'd14);
        @(negedge clock);
        check("t1_go_latency", 32'(chk_go), 32'd1);
        check("t1_chk_base", 32'(chk_base), 32'd11);
        check("t1_chk_ending", 32'(chk_ending), 32'd14);
        wait_rsp("t1_rsp");

        // 2: back-to-back queue, responses in order, go drops between jobs
        g0 = go_rises;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 5'd2, 5'd6));
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 5'd7, 5'd11));
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 5'd11, 5'd14));
        push_req(5'd2, 5'd6);
        push_req(5'd7, 5'd11);
        push_req(5'd11, 5'd14);
        wait_rsp("t2_rsp0");
        wait_rsp("t2_rsp1");
        wait_rsp("t2_rsp2");
        check("t2_go_pulses", 32'(go_rises - g0), 32'd3);

        // done while idle is ignored
        m_spur = 1'b1;
        repeat (4) @(negedge clock);
        check("idle_done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_done_busy", 32'(busy), 32'd0);
        check("idle_done_go", 32'(chk_go), 32'd0);
        m_spur = 1'b0;
        repeat (3) @(negedge clock);

        // 3: fill under backpressure; one job in flight plus DEPTH queued
        t3b = '{5'd11, 5'd7, 5'd2, 5'd7, 5'd9, 5'd12};
        t3e = '{5'd14, 5'd11, 5'd6, 5'd7, 5'd3, 5'd13};
        t3x = '{pack(1'b1, 1'b0, 1'b0, 5'd11, 5'd14), pack(1'b0, 1'b0, 1'b0, 5'd7, 5'd11),
                pack(1'b1, 1'b0, 1'b0, 5'd2, 5'd6),   pack(1'b1, 1'b0, 1'b0, 5'd7, 5'd7),
                pack(1'b0, 1'b1, 1'b0, 5'd9, 5'd3),   pack(1'b1, 1'b0, 1'b0, 5'd12, 5'd13)};
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (!req_ready) break;
            exp_q.push_back(t3x[i]);
            req_valid  = 1'b1;
            req_base   = t3b[i];
            req_ending = t3e[i];
            @(negedge clock);
            acc++;
        end
        req_valid = 1'b0;
        check("t3_accepts", 32'(acc), 32'(DEPTH + 1));
        check("t3_req_ready_full", 32'(req_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        check("t3_rsp_held", 32'(rsp_valid), 32'd1);
        check("t3_rsp_base_held", 32'(rsp_base), 32'd11);
        check("t3_chk_base_held", 32'(chk_base), 32'd11);
        wait_rsp("t3_rsp0");
        wait_rsp("t3_rsp1");
        wait_rsp("t3_rsp2");
        wait_rsp("t3_rsp3");
        wait_rsp("t3_rsp4");
        repeat (2) @(negedge clock);
        check("t3_drained_busy", 32'(busy), 32'd0);

        // 4: rejected request never raises go; single-word request
        g0 = go_rises;
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 5'd9, 5'd3));
        push_req(5'd9, 5'd3);
        wait_rsp("t4_err_rsp");
        repeat (2) @(negedge clock);
        check("t4_no_go", 32'(go_rises - g0), 32'd0);
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 5'd7, 5'd7));
        push_req(5'd7, 5'd7);
        wait_rsp("t4_single");

        // 5: checker never answers -> timeout, then normal service resumes
        m_hang = 1'b1;
        exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 5'd11, 5'd14));
        push_req(5'd11, 5'd14);
        n = 0;
        while (!chk_go && n < 10) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("t5_wait_ge_timeout", 32'(n >= TIMEOUT), 32'd1);
        wait_rsp("t5_tmo_rsp");
        m_hang = 1'b0;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 5'd2, 5'd6));
        push_req(5'd2, 5'd6);
        wait_rsp("t5_after");

        // 6: reset during ISSUE flushes everything
        m_hang = 1'b1;
        push_req(5'd11, 5'd14);
        push_req(5'd2, 5'd6);
        n = 0;
        while (!chk_go && n < 10) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("t6_go_before", 32'(chk_go), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_go_async", 32'(chk_go), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_req_ready", 32'(req_ready), 32'd1);
        m_hang = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        seen_valid = 1'b0;
        seen_go    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            seen_valid |= rsp_valid;
            seen_go    |= chk_go;
        end
        check("t6_no_stale_rsp", 32'(seen_valid), 32'd0);
        check("t6_no_stale_go", 32'(seen_go), 32'd0);
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 5'd7, 5'd7));
        push_req(5'd7, 5'd7);
        wait_rsp("t6_after");
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
